// File: rtl/fifo_ctrl_sclk.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_sclk
//
// Single-clock FIFO controller that runs an external true dual-port RAM
// (true_dpram_sclk) as an N-deep FIFO. RAM port A is the write port, and
// RAM port B is the read port. Port B is held in read mode permanently.
// The block owns the write/read pointers and the fill count. It produces the
// status flags (full/empty), the watermark flags and the read-valid strobe.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined   : sticky overflow/underflow error flags, cleared only by reset
//   undefined : overflow/underflow tied to 0, no error registers
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   push         in   write request
//   data_in      in   write data
//   pop          in   read request
//   data_out     out  read data, taken straight from the RAM registered output
//   valid_out    out  data_out holds the word popped on the previous edge
//   full/empty   out  fill-count decodes
//   almost_full  out  fifo_count >= ALMOST_FULL_TH
//   almost_empty out  fifo_count <= ALMOST_EMPTY_TH
//   fifo_count   out  number of words stored
//   overflow     out  push attempted while full (sticky, optional)
//   underflow    out  pop attempted while empty (sticky, optional)
//   ram_*        out/in  RAM port A (write) and port B (read) connections
// -----------------------------------------------------------------------------
module fifo_ctrl_sclk #(
    parameter int LINE_SIZE       = 12,
    parameter int BLOCK_SIZE      = 8,   // must equal 2**ADDRESS_SIZE
    parameter int ADDRESS_SIZE    = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [LINE_SIZE-1:0]    data_in,
    input  logic                    pop,
    output logic [LINE_SIZE-1:0]    data_out,
    output logic                    valid_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_SIZE:0]   fifo_count,
    output logic                    overflow,
    output logic                    underflow,
    output logic [LINE_SIZE-1:0]    ram_data_w,
    output logic [ADDRESS_SIZE-1:0] ram_wr_ptr,
    output logic                    ram_wr_e,
    output logic [LINE_SIZE-1:0]    ram_data_r,
    output logic [ADDRESS_SIZE-1:0] ram_rd_ptr,
    output logic                    ram_rd_e,
    input  logic [LINE_SIZE-1:0]    ram_q_r
);

    localparam int CW = ADDRESS_SIZE + 1;

    logic [ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q,  count_d;
    logic                    valid_q;
    logic                    push_ok;
    logic                    pop_ok;

    // Status flags decode the registered count only, so they are glitch-free
    // relative to the current cycle's push/pop requests.
    assign full         = (count_q == CW'(BLOCK_SIZE));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(ALMOST_FULL_TH));
    assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_TH));
    assign fifo_count   = count_q;

    // A push while full is dropped even if a pop frees a slot on the same
    // edge. A pop while empty is dropped even if a push lands on the same
    // edge. Because of this, the read address never collides with a live write.
    assign push_ok = push & ~full;
    assign pop_ok  = pop  & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap through natural ADDRESS_SIZE overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // The RAM registers ram[rd_ptr] on the same edge as the pop. The
            // word is therefore presented together with this strobe.
            valid_q  <= pop_ok;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = ram_q_r;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push & full)  overflow_q  <= 1'b1;
            if (pop  & empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // RAM port A: write-only.
    assign ram_data_w = data_in;
    assign ram_wr_ptr = wr_ptr_q;
    assign ram_wr_e   = push_ok;

    // RAM port B: read-only. The write-enable is held at its read level, and
    // the write data is parked at zero.
    assign ram_data_r = '0;
    assign ram_rd_ptr = rd_ptr_q;
    assign ram_rd_e   = 1'b1;

endmodule

// File: tb/tb_fifo_ctrl_sclk.sv
module tb_fifo_ctrl_sclk;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [11:0] data_in;
    logic        pop;
    logic [11:0] data_out;
    logic        valid_out;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  fifo_count;
    logic        overflow, underflow;
    logic [11:0] ram_data_w;
    logic [2:0]  ram_wr_ptr;
    logic        ram_wr_e;
    logic [11:0] ram_data_r;
    logic [2:0]  ram_rd_ptr;
    logic        ram_rd_e;
    logic [11:0] ram_q_r;

    always #5 clk = ~clk;

    fifo_ctrl_sclk dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow),
        .ram_data_w(ram_data_w), .ram_wr_ptr(ram_wr_ptr), .ram_wr_e(ram_wr_e),
        .ram_data_r(ram_data_r), .ram_rd_ptr(ram_rd_ptr), .ram_rd_e(ram_rd_e),
        .ram_q_r(ram_q_r)
    );

    // Behavioural dual-port RAM with a registered port-B read.
    logic [11:0] mem [8];
    always_ff @(posedge clk) begin
        if (ram_wr_e) mem[ram_wr_ptr] <= ram_data_w;
        ram_q_r <= mem[ram_rd_ptr];
    end

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Reference model: a queue of stored words plus the expected strobes.
    logic [11:0] q[$];
    logic        m_valid;
    logic [11:0] m_data;
    logic        m_ovf, m_udf;
    logic        m_push_ok;
    logic [3:0]  m_count;
    logic        seen_wr_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step(input logic p, input logic [11:0] d, input logic r, input logic rst);
        logic f_old, e_old;
        push = p; data_in = d; pop = r; reset = rst;
        #1;
        seen_wr_e = ram_wr_e;
        f_old = (q.size() == 8);
        e_old = (q.size() == 0);
        m_push_ok = p && !f_old && !rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            m_valid = r && !e_old;
            if (m_valid) m_data = q.pop_front();
            if (p && !f_old) q.push_back(d);
            if (ERR_EN && p && f_old) m_ovf = 1'b1;
            if (ERR_EN && r && e_old) m_udf = 1'b1;
        end
        m_count = 4'(q.size());
        #1;
        $display("step push=%0b din=%03h pop=%0b rst=%0b | count=%0d valid=%0b dout=%03h full=%0b empty=%0b af=%0b ae=%0b ovf=%0b udf=%0b",
                 p, d, r, rst, fifo_count, valid_out, data_out, full, empty,
                 almost_full, almost_empty, overflow, underflow);
    endtask

    task automatic test_reset();
        step(1'b0, 12'h0, 1'b0, 1'b1);
        step(1'b0, 12'h0, 1'b0, 1'b1);
        n_checks++; if (fifo_count !== 4'd0)   begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_checks++; if (empty !== 1'b1)        begin n_fail++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        n_checks++; if (full !== 1'b0)         begin n_fail++; $display("FAIL reset_full got=%0b exp=0", full); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got=%0b exp=1", almost_empty); end
        n_checks++; if (almost_full !== 1'b0)  begin n_fail++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
        n_checks++; if (valid_out !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin n_fail++; $display("FAIL reset_errflags got=%0b%0b exp=00", overflow, underflow); end
        n_checks++; if (ram_rd_e !== 1'b1 || ram_data_r !== 12'h0)
            begin n_fail++; $display("FAIL reset_portb got rd_e=%0b data_r=%03h exp 1/000", ram_rd_e, ram_data_r); end
        n_checks++; if (ram_wr_ptr !== 3'd0 || ram_rd_ptr !== 3'd0)
            begin n_fail++; $display("FAIL reset_ptrs got wr=%0d rd=%0d exp 0/0", ram_wr_ptr, ram_rd_ptr); end
    endtask

    task automatic test_fill();
        int pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 12'(i), 1'b0, 1'b0);
            if (seen_wr_e === 1'b1) pulses++;
            n_checks++; if (fifo_count !== 4'(i))
                begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", fifo_count, i); end
            n_checks++; if (almost_full !== (i >= 6))
                begin n_fail++; $display("FAIL fill_af got=%0b exp=%0b at count %0d", almost_full, (i >= 6), i); end
            n_checks++; if (full !== (i == 8))
                begin n_fail++; $display("FAIL fill_full got=%0b exp=%0b at count %0d", full, (i == 8), i); end
        end
        n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL fill_wr_e_pulses got=%0d exp=8", pulses); end
        n_checks++; if (ram_wr_ptr !== 3'd0) begin n_fail++; $display("FAIL fill_wrptr_wrap got=%0d exp=0", ram_wr_ptr); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 12'h0, 1'b1, 1'b0);
            n_checks++; if (valid_out !== 1'b1 || data_out !== 12'(i))
                begin n_fail++; $display("FAIL drain_word got v=%0b d=%03h exp v=1 d=%03h", valid_out, data_out, 12'(i)); end
            n_checks++; if (almost_empty !== (m_count <= 4'd2))
                begin n_fail++; $display("FAIL drain_ae got=%0b exp=%0b at count %0d", almost_empty, (m_count <= 4'd2), m_count); end
        end
        step(1'b0, 12'h0, 1'b0, 1'b0);
        n_checks++; if (valid_out !== 1'b0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL drain_end got v=%0b empty=%0b exp v=0 empty=1", valid_out, empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 12'h0AA, 1'b1, 1'b0);
            n_checks++; if (fifo_count !== 4'd4)
                begin n_fail++; $display("FAIL simul_count got=%0d exp=4", fifo_count); end
            n_checks++; if (valid_out !== 1'b1 || data_out !== m_data)
                begin n_fail++; $display("FAIL simul_word got v=%0b d=%03h exp v=1 d=%03h", valid_out, data_out, m_data); end
            n_checks++; if (3'(ram_wr_ptr - ram_rd_ptr) !== 3'd4)
                begin n_fail++; $display("FAIL simul_ptr_gap got wr=%0d rd=%0d exp gap 4", ram_wr_ptr, ram_rd_ptr); end
        end
    endtask

    task automatic test_boundary();
        while (q.size() > 0) step(1'b0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
        step(1'b1, 12'h5A5, 1'b1, 1'b0);
        n_checks++; if (fifo_count !== 4'd7)
            begin n_fail++; $display("FAIL bound_full_count got=%0d exp=7", fifo_count); end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 12'h0, 1'b1, 1'b0);
            n_checks++; if (valid_out !== 1'b1 || data_out !== m_data)
                begin n_fail++; $display("FAIL bound_drain got v=%0b d=%03h exp v=1 d=%03h", valid_out, data_out, m_data); end
        end
        step(1'b1, 12'h321, 1'b1, 1'b0);
        n_checks++; if (fifo_count !== 4'd1 || valid_out !== 1'b0)
            begin n_fail++; $display("FAIL bound_empty got count=%0d v=%0b exp count=1 v=0", fifo_count, valid_out); end
        step(1'b0, 12'h0, 1'b1, 1'b0);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 12'h321)
            begin n_fail++; $display("FAIL bound_first_word got v=%0b d=%03h exp v=1 d=321", valid_out, data_out); end
    endtask

    task automatic test_errors();
        step(1'b0, 12'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 12'(i + 16), 1'b0, 1'b0);
        step(1'b1, 12'hFFF, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b0, 1'b0);
        n_checks++; if (overflow !== ERR_EN || underflow !== 1'b0)
            begin n_fail++; $display("FAIL err_overflow got ovf=%0b udf=%0b exp ovf=%0b udf=0", overflow, underflow, ERR_EN); end
        for (int i = 0; i < 8; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        n_checks++; if (overflow !== ERR_EN || underflow !== ERR_EN || valid_out !== 1'b0)
            begin n_fail++; $display("FAIL err_underflow got ovf=%0b udf=%0b v=%0b exp ovf=%0b udf=%0b v=0", overflow, underflow, valid_out, ERR_EN, ERR_EN); end
        step(1'b0, 12'h0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin n_fail++; $display("FAIL err_reset_clear got ovf=%0b udf=%0b exp 0/0", overflow, underflow); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) step(1'b1, 12'(i + 32), 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b1);
        n_checks++; if (fifo_count !== 4'd0 || empty !== 1'b1 || valid_out !== 1'b0)
            begin n_fail++; $display("FAIL midreset got count=%0d empty=%0b v=%0b exp 0/1/0", fifo_count, empty, valid_out); end
        step(1'b1, 12'h123, 1'b0, 1'b0);
        step(1'b0, 12'h0, 1'b1, 1'b0);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 12'h123)
            begin n_fail++; $display("FAIL midreset_word got v=%0b d=%03h exp v=1 d=123", valid_out, data_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
            n_checks++; if (fifo_count !== m_count || full !== (m_count == 4'd8) || empty !== (m_count == 4'd0))
                begin n_fail++; $display("FAIL rand_count got=%0d f=%0b e=%0b exp=%0d", fifo_count, full, empty, m_count); end
            n_checks++; if (almost_full !== (m_count >= 4'd6) || almost_empty !== (m_count <= 4'd2))
                begin n_fail++; $display("FAIL rand_watermark got af=%0b ae=%0b at count %0d", almost_full, almost_empty, m_count); end
            n_checks++; if (valid_out !== m_valid || (m_valid && data_out !== m_data))
                begin n_fail++; $display("FAIL rand_read got v=%0b d=%03h exp v=%0b d=%03h", valid_out, data_out, m_valid, m_data); end
            n_checks++; if (overflow !== m_ovf || underflow !== m_udf)
                begin n_fail++; $display("FAIL rand_err got ovf=%0b udf=%0b exp ovf=%0b udf=%0b", overflow, underflow, m_ovf, m_udf); end
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        m_valid = 1'b0; m_data = '0; m_ovf = 1'b0; m_udf = 1'b0;
        m_count = '0; m_push_ok = 1'b0; seen_wr_e = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_boundary();
        test_errors();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
